// File: rtl/qa_driver_mem_rd_buf.sv
// Credit-limited read tracker and in-order response buffer between a client read port
// and the driver memory-read interface.
module qa_driver_mem_rd_buf #(
   parameter int MAX_OUTSTANDING = 16,
   parameter int ADDR_W          = 42,
   parameter int DATA_W          = 512,
   localparam int CNT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_req_valid,
   input  logic [ADDR_W-1:0] rd_req_addr,
   input  logic              rd_req_cached,
   input  logic              rd_req_check_order,
   output logic              rd_req_ready,
   output logic              rd_rsp_valid,
   output logic [DATA_W-1:0] rd_rsp_data,
   input  logic              rd_rsp_ready,
   output logic [ADDR_W-1:0] mem_read_req_addr,
   output logic              mem_read_req_cached,
   output logic              mem_read_req_check_order,
   output logic              mem_read_req_enable,
   input  logic              mem_read_req_rdy,
   input  logic [DATA_W-1:0] mem_read_rsp_data,
   input  logic              mem_read_rsp_rdy,
   output logic [CNT_W-1:0]  outstanding,
   output logic              idle,
   output logic              overflow_err
);

   localparam int IDX_W = CNT_W - 1;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic [CNT_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  rd_ptr;
   logic [DATA_W-1:0] mem [MAX_OUTSTANDING];

   logic issue;
   logic pop;
   logic dec;
   logic fifo_full;
   logic fifo_empty;
   logic wr_en;
   logic no_credit_rsp;

   // Handshake: a transfer happens on a port in every cycle where its valid and ready are both 1.
   assign rd_req_ready = mem_read_req_rdy && (outstanding < MAX_CNT) && !reset;
   assign issue        = rd_req_valid && rd_req_ready;

   assign mem_read_req_enable      = issue;
   assign mem_read_req_addr        = rd_req_addr;
   assign mem_read_req_cached      = rd_req_cached;
   assign mem_read_req_check_order = rd_req_check_order;

   // Pointers carry one extra bit so a full FIFO is told apart from an empty one.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[CNT_W-1] != rd_ptr[CNT_W-1]) &&
                       (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

   assign rd_rsp_valid = !fifo_empty && !reset;
   assign rd_rsp_data  = mem[rd_ptr[IDX_W-1:0]];
   assign pop          = rd_rsp_valid && rd_rsp_ready;

   // A pop in the same cycle frees the slot the incoming write lands in.
   assign wr_en = mem_read_rsp_rdy && (!fifo_full || pop);

   // Popping an entry that arrived without a credit must not wrap the counter below zero.
   assign dec = pop && (outstanding != '0);

   assign no_credit_rsp = mem_read_rsp_rdy && ((fifo_full && !pop) || (outstanding == '0));

   assign idle = (outstanding == '0) && fifo_empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outstanding <= '0;
      end else if (issue && !dec) begin
         outstanding <= outstanding + ONE;
      end else if (!issue && dec) begin
         outstanding <= outstanding - ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_err <= 1'b0;
      end else if (no_credit_rsp) begin
         overflow_err <= 1'b1;
      end
   end

   // Storage holds don't-care data until written, so it carries no reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr[IDX_W-1:0]] <= mem_read_rsp_data;
      end
   end

endmodule

// File: tb/tb_qa_driver_mem_rd_buf.sv
// Directed bench for qa_driver_mem_rd_buf: reset values, single read, credit limit,
// backpressure, full-FIFO concurrency, overflow and asynchronous reset.
module tb_qa_driver_mem_rd_buf;

   localparam int MAX    = 16;
   localparam int ADDR_W = 42;
   localparam int DATA_W = 512;
   localparam int CNT_W  = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic              rd_req_valid;
   logic [ADDR_W-1:0] rd_req_addr;
   logic              rd_req_cached;
   logic              rd_req_check_order;
   logic              rd_req_ready;
   logic              rd_rsp_valid;
   logic [DATA_W-1:0] rd_rsp_data;
   logic              rd_rsp_ready;
   logic [ADDR_W-1:0] mem_read_req_addr;
   logic              mem_read_req_cached;
   logic              mem_read_req_check_order;
   logic              mem_read_req_enable;
   logic              mem_read_req_rdy;
   logic [DATA_W-1:0] mem_read_rsp_data;
   logic              mem_read_rsp_rdy;
   logic [CNT_W-1:0]  outstanding;
   logic              idle;
   logic              overflow_err;

   int n_checks = 0;
   int n_err    = 0;
   int n_en;

   qa_driver_mem_rd_buf #(
      .MAX_OUTSTANDING(MAX),
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .rd_req_valid(rd_req_valid),
      .rd_req_addr(rd_req_addr),
      .rd_req_cached(rd_req_cached),
      .rd_req_check_order(rd_req_check_order),
      .rd_req_ready(rd_req_ready),
      .rd_rsp_valid(rd_rsp_valid),
      .rd_rsp_data(rd_rsp_data),
      .rd_rsp_ready(rd_rsp_ready),
      .mem_read_req_addr(mem_read_req_addr),
      .mem_read_req_cached(mem_read_req_cached),
      .mem_read_req_check_order(mem_read_req_check_order),
      .mem_read_req_enable(mem_read_req_enable),
      .mem_read_req_rdy(mem_read_req_rdy),
      .mem_read_rsp_data(mem_read_rsp_data),
      .mem_read_rsp_rdy(mem_read_rsp_rdy),
      .outstanding(outstanding),
      .idle(idle),
      .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] mk(input int i);
      logic [31:0] w;
      w = 32'hC0DE_0000 + 32'(i);
      return {16{w}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset              = 1'b1;
      rd_req_valid       = 1'b1;
      rd_req_addr        = '0;
      rd_req_cached      = 1'b0;
      rd_req_check_order = 1'b0;
      rd_rsp_ready       = 1'b0;
      mem_read_req_rdy   = 1'b1;
      mem_read_rsp_data  = '0;
      mem_read_rsp_rdy   = 1'b0;

      // Reset values, with request and driver-ready both high
      tick(); tick(); settle();
      chk("rst_req_ready", DATA_W'(rd_req_ready), '0);
      chk("rst_enable", DATA_W'(mem_read_req_enable), '0);
      chk("rst_rsp_valid", DATA_W'(rd_rsp_valid), '0);
      chk("rst_idle", DATA_W'(idle), DATA_W'(1));
      chk("rst_outstanding", DATA_W'(outstanding), '0);
      chk("rst_overflow", DATA_W'(overflow_err), '0);

      // Single read at 0x100, response 5 cycles later
      reset              = 1'b0;
      rd_req_valid       = 1'b1;
      rd_req_addr        = ADDR_W'(64'h100);
      rd_req_cached      = 1'b1;
      rd_req_check_order = 1'b0;
      settle();
      chk("single_ready", DATA_W'(rd_req_ready), DATA_W'(1));
      chk("single_enable", DATA_W'(mem_read_req_enable), DATA_W'(1));
      chk("single_addr", DATA_W'(mem_read_req_addr), DATA_W'(64'h100));
      chk("single_cached", DATA_W'(mem_read_req_cached), DATA_W'(1));
      chk("single_check_order", DATA_W'(mem_read_req_check_order), '0);
      tick();
      rd_req_valid = 1'b0;
      settle();
      chk("single_outst_1", DATA_W'(outstanding), DATA_W'(1));
      tick(); tick(); tick(); tick();
      mem_read_rsp_rdy  = 1'b1;
      mem_read_rsp_data = mk(1);
      settle();
      chk("single_not_yet_valid", DATA_W'(rd_rsp_valid), '0);
      tick();
      mem_read_rsp_rdy  = 1'b0;
      mem_read_rsp_data = '0;
      settle();
      chk("single_rsp_valid", DATA_W'(rd_rsp_valid), DATA_W'(1));
      chk("single_rsp_data", rd_rsp_data, mk(1));
      chk("single_outst_held", DATA_W'(outstanding), DATA_W'(1));
      rd_rsp_ready = 1'b1;
      tick();
      rd_rsp_ready = 1'b0;
      settle();
      chk("single_outst_0", DATA_W'(outstanding), '0);
      chk("single_rsp_gone", DATA_W'(rd_rsp_valid), '0);
      chk("single_idle", DATA_W'(idle), DATA_W'(1));
      chk("single_no_ovf", DATA_W'(overflow_err), '0);

      // Credit limit: continuous requests with no pops
      rd_req_valid = 1'b1;
      n_en = 0;
      for (int i = 0; i < 20; i++) begin
         rd_req_addr = ADDR_W'(i);
         settle();
         if (mem_read_req_enable) n_en++;
         tick();
      end
      settle();
      chk("credit_enables", DATA_W'(n_en), DATA_W'(16));
      chk("credit_ready_low", DATA_W'(rd_req_ready), '0);
      chk("credit_outst_16", DATA_W'(outstanding), DATA_W'(16));

      // Fill the FIFO with 16 responses while the request stays blocked
      n_en = 0;
      for (int i = 0; i < 16; i++) begin
         mem_read_rsp_rdy  = 1'b1;
         mem_read_rsp_data = mk(100 + i);
         settle();
         if (mem_read_req_enable) n_en++;
         tick();
      end
      mem_read_rsp_rdy = 1'b0;
      settle();
      chk("fill_no_issue", DATA_W'(n_en), '0);
      chk("fill_rsp_valid", DATA_W'(rd_rsp_valid), DATA_W'(1));
      chk("fill_head", rd_rsp_data, mk(100));
      chk("fill_no_ovf", DATA_W'(overflow_err), '0);
      tick(); tick();
      settle();
      chk("stall_head_stable", rd_rsp_data, mk(100));

      // One pop frees exactly one credit
      rd_rsp_ready = 1'b1;
      settle();
      chk("pop_data", rd_rsp_data, mk(100));
      chk("pop_cycle_not_ready", DATA_W'(rd_req_ready), '0);
      tick();
      rd_rsp_ready = 1'b0;
      n_en = 0;
      for (int i = 0; i < 5; i++) begin
         settle();
         if (mem_read_req_enable) n_en++;
         tick();
      end
      rd_req_valid = 1'b0;
      settle();
      chk("pop_one_issue", DATA_W'(n_en), DATA_W'(1));
      chk("pop_outst_16", DATA_W'(outstanding), DATA_W'(16));
      chk("pop_next_head", rd_rsp_data, mk(101));

      // Refill to 16 entries, then write and pop in the same cycle
      mem_read_rsp_rdy  = 1'b1;
      mem_read_rsp_data = mk(116);
      tick();
      mem_read_rsp_data = mk(117);
      rd_rsp_ready      = 1'b1;
      settle();
      chk("conc_pop_data", rd_rsp_data, mk(101));
      tick();
      mem_read_rsp_rdy = 1'b0;
      rd_rsp_ready     = 1'b0;
      settle();
      chk("conc_no_ovf", DATA_W'(overflow_err), '0);
      chk("conc_outst_15", DATA_W'(outstanding), DATA_W'(15));
      for (int i = 2; i < 18; i++) begin
         rd_rsp_ready = 1'b1;
         settle();
         chk($sformatf("drain_%0d", i), rd_rsp_data, mk(100 + i));
         tick();
      end
      rd_rsp_ready = 1'b0;
      settle();
      chk("drain_empty", DATA_W'(rd_rsp_valid), '0);
      chk("drain_outst_0", DATA_W'(outstanding), '0);
      chk("drain_idle", DATA_W'(idle), DATA_W'(1));

      // Driver backpressure for 10 cycles
      mem_read_req_rdy = 1'b0;
      rd_req_valid     = 1'b1;
      n_en = 0;
      for (int i = 0; i < 10; i++) begin
         settle();
         if (mem_read_req_enable) n_en++;
         tick();
      end
      chk("bp_no_enable", DATA_W'(n_en), '0);
      mem_read_req_rdy = 1'b1;
      settle();
      chk("bp_resume", DATA_W'(mem_read_req_enable), DATA_W'(1));
      tick();
      rd_req_valid = 1'b0;
      settle();
      chk("bp_outst_1", DATA_W'(outstanding), DATA_W'(1));

      // Complete that read, then inject a response with no credit
      mem_read_rsp_rdy  = 1'b1;
      mem_read_rsp_data = mk(200);
      tick();
      mem_read_rsp_rdy = 1'b0;
      rd_rsp_ready     = 1'b1;
      settle();
      chk("bp_rsp_data", rd_rsp_data, mk(200));
      tick();
      rd_rsp_ready = 1'b0;
      settle();
      chk("pre_inj_outst", DATA_W'(outstanding), '0);
      chk("pre_inj_no_ovf", DATA_W'(overflow_err), '0);
      mem_read_rsp_rdy  = 1'b1;
      mem_read_rsp_data = mk(201);
      tick();
      mem_read_rsp_rdy = 1'b0;
      settle();
      chk("inj_ovf", DATA_W'(overflow_err), DATA_W'(1));
      chk("inj_enqueued", DATA_W'(rd_rsp_valid), DATA_W'(1));
      chk("inj_data", rd_rsp_data, mk(201));
      rd_rsp_ready = 1'b1;
      tick();
      rd_rsp_ready = 1'b0;
      tick(); tick(); tick();
      settle();
      chk("inj_ovf_sticky", DATA_W'(overflow_err), DATA_W'(1));
      chk("inj_outst_0", DATA_W'(outstanding), '0);
      chk("inj_idle", DATA_W'(idle), DATA_W'(1));

      // Asynchronous reset mid-burst, checked before any clock edge
      rd_req_valid = 1'b1;
      tick(); tick(); tick();
      mem_read_rsp_rdy  = 1'b1;
      mem_read_rsp_data = mk(300);
      tick();
      settle();
      chk("burst_outst", DATA_W'(outstanding), DATA_W'(4));
      reset = 1'b1;
      #1;
      chk("arst_req_ready", DATA_W'(rd_req_ready), '0);
      chk("arst_enable", DATA_W'(mem_read_req_enable), '0);
      chk("arst_rsp_valid", DATA_W'(rd_rsp_valid), '0);
      chk("arst_idle", DATA_W'(idle), DATA_W'(1));
      chk("arst_outst", DATA_W'(outstanding), '0);
      chk("arst_ovf", DATA_W'(overflow_err), '0);
      rd_req_valid     = 1'b0;
      mem_read_rsp_rdy = 1'b0;
      tick();
      reset = 1'b0;
      settle();
      chk("post_rst_empty", DATA_W'(rd_rsp_valid), '0);

      // Drop on full: 16 credits, 17 responses, no pops
      rd_req_valid = 1'b1;
      for (int i = 0; i < 16; i++) tick();
      rd_req_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         mem_read_rsp_rdy  = 1'b1;
         mem_read_rsp_data = mk(400 + i);
         tick();
      end
      settle();
      chk("full_no_ovf", DATA_W'(overflow_err), '0);
      mem_read_rsp_data = mk(416);
      tick();
      mem_read_rsp_rdy = 1'b0;
      settle();
      chk("full_drop_ovf", DATA_W'(overflow_err), DATA_W'(1));
      for (int i = 0; i < 16; i++) begin
         rd_rsp_ready = 1'b1;
         settle();
         chk($sformatf("full_drain_%0d", i), rd_rsp_data, mk(400 + i));
         tick();
      end
      rd_rsp_ready = 1'b0;
      settle();
      chk("full_dropped_gone", DATA_W'(rd_rsp_valid), '0);
      chk("full_idle", DATA_W'(idle), DATA_W'(1));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
